// File: rtl/decode_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_pkg
// Purpose  : Shared types and constants for the decode stage-2 format mux.
//            Holds the per-channel decode record (ch_payload_t), the
//            normalised output entry (decoded_entry_t), instruction-format
//            codes and a helper that assembles an entry from a record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package decode_mux_pkg;

    localparam int REG_WIDTH     = 5;
    localparam int BIT_WIDTH     = 5;
    localparam int ADDR_SIZE     = 64;
    localparam int OPCODE_WIDTH  = 6;
    localparam int RAW_IMM_WIDTH = 16;
    localparam int XOP_WIDTH     = 10;
    localparam int FMT_WIDTH     = 5;
    localparam int FU_WIDTH      = 2;
    localparam int IMM_WIDTH     = 64;
    localparam int SHIFT_WIDTH   = 6;

    typedef logic [FMT_WIDTH-1:0] fmt_t;

    // Instruction-format codes; 0 is reserved for "no decoder claimed it".
    localparam fmt_t FMT_INVALID = 5'd0;
    localparam fmt_t FMT_A       = 5'd1;
    localparam fmt_t FMT_B       = 5'd2;
    localparam fmt_t FMT_D       = 5'd3;
    localparam fmt_t FMT_DS      = 5'd4;
    localparam fmt_t FMT_I       = 5'd5;
    localparam fmt_t FMT_M       = 5'd6;
    localparam fmt_t FMT_MD      = 5'd7;
    localparam fmt_t FMT_MDS     = 5'd8;
    localparam fmt_t FMT_SC      = 5'd9;
    localparam fmt_t FMT_X       = 5'd10;
    localparam fmt_t FMT_XFL     = 5'd11;
    localparam fmt_t FMT_XFX     = 5'd12;
    localparam fmt_t FMT_XL      = 5'd13;
    localparam fmt_t FMT_XO      = 5'd14;
    localparam fmt_t FMT_XS      = 5'd15;
    localparam fmt_t FMT_Z22     = 5'd16;
    localparam fmt_t FMT_Z23     = 5'd17;

    typedef struct packed {
        logic [REG_WIDTH-1:0]     reg1;
        logic [REG_WIDTH-1:0]     reg2;
        logic [REG_WIDTH-1:0]     reg3;
        logic                     reg1En;
        logic                     reg2En;
        logic                     reg3En;
        logic                     reg2ValOrZero;
        logic                     reg3IsImm;
        logic [BIT_WIDTH-1:0]     bit1;
        logic [BIT_WIDTH-1:0]     bit2;
        logic                     bit1En;
        logic                     bit2En;
        logic [RAW_IMM_WIDTH-1:0] immRaw;
        logic                     immSigned;
        logic [SHIFT_WIDTH-1:0]   immShift;
        logic                     immEnable;
        logic [XOP_WIDTH-1:0]     xOpcode;
        logic                     xOpcodeEnable;
        logic [FU_WIDTH-1:0]      fuCode;
        fmt_t                     format;
    } ch_payload_t;

    localparam int PAYLOAD_W = $bits(ch_payload_t);

    typedef struct packed {
        logic [REG_WIDTH-1:0]    reg1;
        logic [REG_WIDTH-1:0]    reg2;
        logic [REG_WIDTH-1:0]    reg3;
        logic                    reg1En;
        logic                    reg2En;
        logic                    reg3En;
        logic                    reg2ValOrZero;
        logic                    reg3IsImm;
        logic [BIT_WIDTH-1:0]    bit1;
        logic [BIT_WIDTH-1:0]    bit2;
        logic                    bit1En;
        logic                    bit2En;
        logic [IMM_WIDTH-1:0]    imm;
        logic                    immSigned;
        logic                    immEnable;
        logic [XOP_WIDTH-1:0]    xOpcode;
        logic                    xOpcodeEnable;
        logic [FU_WIDTH-1:0]     fuCode;
        fmt_t                    format;
        logic [ADDR_SIZE-1:0]    address;
        logic [OPCODE_WIDTH-1:0] opcode;
        logic                    multiHot;
        logic                    noneHot;
    } decoded_entry_t;

    localparam int ENTRY_W = $bits(decoded_entry_t);

    // Copies the selected record into an output entry, substituting the
    // already-normalised 64-bit immediate for the raw/shift fields.
    function automatic decoded_entry_t build_entry(
        input ch_payload_t             p,
        input logic [IMM_WIDTH-1:0]    imm,
        input logic [ADDR_SIZE-1:0]    addr,
        input logic [OPCODE_WIDTH-1:0] opc,
        input logic                    multi_hot,
        input logic                    none_hot
    );
        decoded_entry_t e;
        e.reg1          = p.reg1;
        e.reg2          = p.reg2;
        e.reg3          = p.reg3;
        e.reg1En        = p.reg1En;
        e.reg2En        = p.reg2En;
        e.reg3En        = p.reg3En;
        e.reg2ValOrZero = p.reg2ValOrZero;
        e.reg3IsImm     = p.reg3IsImm;
        e.bit1          = p.bit1;
        e.bit2          = p.bit2;
        e.bit1En        = p.bit1En;
        e.bit2En        = p.bit2En;
        e.imm           = imm;
        e.immSigned     = p.immSigned;
        e.immEnable     = p.immEnable;
        e.xOpcode       = p.xOpcode;
        e.xOpcodeEnable = p.xOpcodeEnable;
        e.fuCode        = p.fuCode;
        e.format        = p.format;
        e.address       = addr;
        e.opcode        = opc;
        e.multiHot      = multi_hot;
        e.noneHot       = none_hot;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_mux_stage_imm_normalise.sv
`default_nettype none
// ============================================================================
// Module   : imm_normalise
// Purpose  : Combinational immediate normaliser. Sign- or zero-extends the
//            raw immediate to 64 bits, then shifts it left by 0..63.
//            A cleared enable forces the result to zero.
// Ports    : raw_i     - raw immediate from the selected channel
//            signed_i  - 1 = sign-extend, 0 = zero-extend
//            shift_i   - left-shift amount
//            enable_i  - immediate present
//            imm_o     - normalised 64-bit immediate
// Revision : 1.0 - initial release
// ============================================================================
module imm_normalise
    import decode_mux_pkg::*;
(
    input  logic [RAW_IMM_WIDTH-1:0] raw_i,
    input  logic                     signed_i,
    input  logic [SHIFT_WIDTH-1:0]   shift_i,
    input  logic                     enable_i,
    output logic [IMM_WIDTH-1:0]     imm_o
);

    logic                 w_fill;
    logic [IMM_WIDTH-1:0] w_ext;

    assign w_fill = signed_i & raw_i[RAW_IMM_WIDTH-1];
    assign w_ext  = {{(IMM_WIDTH-RAW_IMM_WIDTH){w_fill}}, raw_i};
    assign imm_o  = enable_i ? (w_ext << shift_i) : '0;

endmodule
`default_nettype wire

// File: rtl/decode_mux_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_stage
// Purpose  : Decode stage-2 format multiplexer. Picks the lowest-index
//            format decoder that claimed the instruction, normalises its
//            immediate, flags none-hot / multi-hot selects, and buffers the
//            result in a 2-entry FIFO toward register-read/dispatch.
// Ports    : clock_i, reset_i (sync, active high), flush_i
//            valid_i/ready_o          - upstream handshake
//            instructionAddress_i, opcode_i, chValid_i, chPayload_i
//            valid_o/ready_i          - downstream handshake
//            entry_o                  - packed decoded_entry_t at FIFO head
//            illegalCount_o           - saturating none-hot counter
// Revision : 1.0 - initial release
// ============================================================================
module decode_mux_stage
    import decode_mux_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [ADDR_SIZE-1:0]        instructionAddress_i,
    input  logic [OPCODE_WIDTH-1:0]     opcode_i,
    input  logic [NUM_CH-1:0]           chValid_i,
    input  logic [NUM_CH*PAYLOAD_W-1:0] chPayload_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [ENTRY_W-1:0]          entry_o,
    output logic [CNT_WIDTH-1:0]        illegalCount_o
);

    localparam int HOT_W = $clog2(NUM_CH + 1);

    // ------------------------------------------------------------------
    // Channel select and hot-count
    // ------------------------------------------------------------------
    ch_payload_t          w_sel_payload;
    logic [HOT_W-1:0]     w_hot_count;
    logic                 w_hit;
    logic                 w_multi_hot;
    logic [IMM_WIDTH-1:0] w_imm;
    decoded_entry_t       w_entry;

    // Walking from the top index down lets the lowest set bit overwrite last.
    // With no hit the payload stays zero, which already yields FMT_INVALID,
    // all enables clear and (immEnable=0) a zero immediate.
    always_comb begin
        w_sel_payload = '0;
        w_hot_count   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chValid_i[i]) begin
                w_sel_payload = chPayload_i[i*PAYLOAD_W +: PAYLOAD_W];
            end
            w_hot_count = w_hot_count + HOT_W'(chValid_i[i]);
        end
    end

    assign w_hit       = |chValid_i;
    assign w_multi_hot = (w_hot_count > HOT_W'(1));

    imm_normalise u_imm_normalise (
        .raw_i    (w_sel_payload.immRaw),
        .signed_i (w_sel_payload.immSigned),
        .shift_i  (w_sel_payload.immShift),
        .enable_i (w_sel_payload.immEnable),
        .imm_o    (w_imm)
    );

    assign w_entry = build_entry(w_sel_payload, w_imm, instructionAddress_i,
                                 opcode_i, w_multi_hot, ~w_hit);

    // ------------------------------------------------------------------
    // 2-entry output FIFO and illegal counter
    // ------------------------------------------------------------------
    decoded_entry_t       mem_q [2];
    logic [1:0]           count_q;
    logic                 rdPtr_q;
    logic                 wrPtr_q;
    logic [CNT_WIDTH-1:0] illegalCount_q;
    logic                 w_push;
    logic                 w_pop;

    // ready_o comes only from the registered count, so ready_i never
    // reaches it combinationally.
    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign w_push  = valid_i & ready_o & ~flush_i;
    assign w_pop   = valid_o & ready_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q        <= 2'd0;
            rdPtr_q        <= 1'b0;
            wrPtr_q        <= 1'b0;
            mem_q[0]       <= '0;
            mem_q[1]       <= '0;
            illegalCount_q <= '0;
        end else if (flush_i) begin
            // Buffered entries and the same-cycle input are dropped; the
            // illegal counter keeps its history.
            count_q <= 2'd0;
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
        end else begin
            if (w_push) begin
                mem_q[wrPtr_q] <= w_entry;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (w_pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (w_push && !w_hit && (illegalCount_q != '1)) begin
                illegalCount_q <= illegalCount_q + CNT_WIDTH'(1);
            end
        end
    end

    assign entry_o        = valid_o ? mem_q[rdPtr_q] : '0;
    assign illegalCount_o = illegalCount_q;

endmodule
`default_nettype wire
